prm_edge_chk_engine: RTL
========================

Name: prm_edge_chk_engine

Overview:
- Programmable, sequential successor to the fixed per-edge obstacle truth tables (one hard-coded sum-of-products per edge).
- Holds a loadable table of product terms ("cubes"), each tagged with an edge id.
- Scans the table against one quantised configuration word per query and returns a mask vector covering all NUM_EDGES edges at once.
- Sits between the configuration quantiser and the PRM planner's edge-validity bookkeeping.

Parameters:
- CFG_W, 15: configuration bits per query. The legacy inputs A..O map to bits 0..14.
- NUM_EDGES, 8: edges checked per query; width of the result mask.
- DEPTH, 512: cube table entries. Must be a power of 2.
- LANES, 4: cubes evaluated per cycle. Must divide DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  cube write strobe.
- cfg_addr  in  log2(DEPTH)  cube index to write.
- cfg_care  in  CFG_W  care mask; 1 means the bit participates in the cube.
- cfg_val  in  CFG_W  required bit values where care=1.
- cfg_edge  in  max(1,log2(NUM_EDGES))  edge the cube contributes to.
- cfg_ent_vld  in  1  entry valid bit written with the cube.
- cfg_num_we  in  1  strobe to load the active cube count.
- cfg_num  in  log2(DEPTH)+1  active cube count, 0..DEPTH.
- cfg_err  out  1  one-cycle pulse when a config write is dropped.
- q_valid  in  1  query valid.
- q_ready  out  1  engine can accept a query.
- q_cfg  in  CFG_W  quantised configuration.
- r_valid  out  1  result valid.
- r_ready  in  1  result consumer ready.
- r_mask  out  NUM_EDGES  bit e=1 means edge e is blocked.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values: all table entry-valid bits=0, active count=0, q_ready=1, r_valid=0, r_mask=0, busy=0, cfg_err=0, state=IDLE.
- Cube match rule: entry valid, and ((q_cfg ^ val) & care) == 0, and edge id < NUM_EDGES. A matching cube ORs 1 into accumulator bit [edge]. A cube with care=0 matches every query.
- IDLE:
  - q_ready=1.
  - On q_valid: latch q_cfg, clear the accumulator, set idx=0.
  - Go to SCAN if count>0, else DONE.
- SCAN:
  - Each cycle evaluate cubes idx..idx+LANES-1. Cubes at index >= count are ignored.
  - idx += LANES.
  - Go to DONE when idx+LANES >= count.
- DONE:
  - r_valid=1; r_mask holds the accumulator and is stable while r_valid=1 and r_ready=0.
  - On r_ready: r_valid drops the next cycle and state returns to IDLE.
  - q_ready stays 0, so there is no back-to-back overlap.
- Latency from query accept to r_valid: ceil(count/LANES)+1 cycles. count=0 gives 1.
- Config writes:
  - Accepted only in IDLE with no query accepted the same cycle.
  - In all other cases the write is dropped and cfg_err pulses for one cycle.
  - If cfg_we and cfg_num_we are both asserted, both take effect.
  - A write to an index >= count is allowed; the entry stays inert until count covers it.
- cfg_num > DEPTH saturates to DEPTH.
- Table storage is flops or inferred RAM read LANES-wide. A registered read may add one pipeline stage; if so, latency grows by exactly 1 and the implementation must document it in a header comment.
- If rst_n is asserted mid-scan, the scan aborts and all outputs return to their reset values. The table is cleared.

Optional Feature:
- Macro PRM_CHK_EARLY_EXIT_EN.
- Defined: in SCAN, if the accumulator, including the current cycle's matches, is all ones, go to DONE immediately. Latency then becomes min(normal, cycle of saturation + 1).
- Undefined: the full scan always runs, and latency depends only on count.

Test Plan:
- Reset, then a query with count=0 -> r_valid 1 cycle after accept, r_mask=0.
- Load cube 0: care=15'h7FFF, val=15'h1234, edge=3; count=1.
  - Query 15'h1234 -> r_mask=8'h08.
  - Query 15'h1235 -> r_mask=8'h00.
- count=9, LANES=4, cubes 0..8 each with care=0 and edge=i%8 -> latency 4 cycles, r_mask=8'hFF. With PRM_CHK_EARLY_EXIT_EN: latency 3 cycles, r_mask=8'hFF.
- Hold r_ready=0 for 5 cycles in DONE -> r_mask stable, q_ready=0, and a second q_valid is not accepted.
- cfg_we during SCAN -> cfg_err pulses, table unchanged; rerunning the prior query gives the identical mask.
- Assert rst_n low mid-scan -> r_valid=0, busy=0, q_ready=1; a following query returns r_mask=0 because the table is cleared.

Source files
------------

// File: rtl/prm_edge_chk_engine.sv
// prm_edge_chk_engine
//   Programmable edge-obstacle checker. A loadable table of DEPTH cubes
//   (care mask, value, edge id, entry-valid) is scanned LANES entries per
//   cycle against one latched configuration word; every matching cube sets
//   its edge's bit in the result mask.
//
//   Table storage is flops with a combinational LANES-wide read, so there is
//   no extra read pipeline stage: latency from query accept to r_valid is
//   ceil(count/LANES)+1 cycles (1 cycle when count is 0).
//
//   Optional build macro: PRM_CHK_EARLY_EXIT_EN
//     defined   - the scan stops as soon as every mask bit is set.
//     undefined - the full active range is always scanned.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_we/addr/care/val/edge/ent_vld   cube write (IDLE only)
//   cfg_num_we/cfg_num    active cube count load, saturates to DEPTH
//   cfg_err               one-cycle pulse after a dropped config write
//   q_valid/q_ready/q_cfg query handshake and configuration word
//   r_valid/r_ready/r_mask result handshake and blocked-edge mask
//   busy                  engine is not idle
module prm_edge_chk_engine #(
    parameter int CFG_W     = 15,
    parameter int NUM_EDGES = 8,
    parameter int DEPTH     = 512,
    parameter int LANES     = 4
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             cfg_we,
    input  logic [$clog2(DEPTH)-1:0]                         cfg_addr,
    input  logic [CFG_W-1:0]                                 cfg_care,
    input  logic [CFG_W-1:0]                                 cfg_val,
    input  logic [((NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1)-1:0] cfg_edge,
    input  logic                                             cfg_ent_vld,
    input  logic                                             cfg_num_we,
    input  logic [$clog2(DEPTH):0]                           cfg_num,
    output logic                                             cfg_err,
    input  logic                                             q_valid,
    output logic                                             q_ready,
    input  logic [CFG_W-1:0]                                 q_cfg,
    output logic                                             r_valid,
    input  logic                                             r_ready,
    output logic [NUM_EDGES-1:0]                             r_mask,
    output logic                                             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1;
    localparam int unsigned NL = LANES;
    localparam logic [EW:0] EDGE_LIM = (EW + 1)'(NUM_EDGES);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LANES_C = CW'(LANES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [CW-1:0]        idx;
    logic [CW-1:0]        count;
    logic [CFG_W-1:0]     q_lat;
    logic [NUM_EDGES-1:0] acc;
    logic [NUM_EDGES-1:0] hits;
    logic [DEPTH-1:0]     ent_vld;

    logic [CFG_W-1:0]     tbl_care [DEPTH];
    logic [CFG_W-1:0]     tbl_val  [DEPTH];
    logic [EW-1:0]        tbl_edge [DEPTH];

    logic                 cfg_ok;
    logic                 cfg_any;
    logic [CW-1:0]        num_sat;
    logic                 last_slice;
    logic                 scan_last;

    // A write is only safe when the engine is idle and not starting a query
    // in the same cycle; otherwise it would race the scan.
    assign cfg_ok  = (state == S_IDLE) && !q_valid;
    assign cfg_any = cfg_we || cfg_num_we;
    assign num_sat = (cfg_num > DEPTH_C) ? DEPTH_C : cfg_num;

    // Evaluate one slice of LANES cubes; lanes past the active count are masked.
    always_comb begin
        logic [CW-1:0] li;
        logic [AW-1:0] a;
        hits = '0;
        li   = '0;
        a    = '0;
        for (int unsigned l = 0; l < NL; l++) begin
            li = idx + CW'(l);
            a  = li[AW-1:0];
            if ((li < count) && ent_vld[a] &&
                (((q_lat ^ tbl_val[a]) & tbl_care[a]) == '0) &&
                ({1'b0, tbl_edge[a]} < EDGE_LIM)) begin
                hits[tbl_edge[a]] = 1'b1;
            end
        end
    end

    assign last_slice = (idx + LANES_C) >= count;

`ifdef PRM_CHK_EARLY_EXIT_EN
    assign scan_last = last_slice || (&(acc | hits));
`else
    assign scan_last = last_slice;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            count   <= '0;
            q_lat   <= '0;
            acc     <= '0;
            ent_vld <= '0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_any && !cfg_ok;
            if (cfg_ok && cfg_we) begin
                ent_vld[cfg_addr] <= cfg_ent_vld;
            end
            if (cfg_ok && cfg_num_we) begin
                count <= num_sat;
            end
            case (state)
                S_IDLE: begin
                    if (q_valid) begin
                        q_lat <= q_cfg;
                        acc   <= '0;
                        idx   <= '0;
                        state <= (count != '0) ? S_SCAN : S_DONE;
                    end
                end
                S_SCAN: begin
                    acc <= acc | hits;
                    idx <= idx + LANES_C;
                    if (scan_last) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (r_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Cube payload needs no reset: an entry is inert until its valid bit is set.
    always_ff @(posedge clk) begin
        if (cfg_ok && cfg_we) begin
            tbl_care[cfg_addr] <= cfg_care;
            tbl_val[cfg_addr]  <= cfg_val;
            tbl_edge[cfg_addr] <= cfg_edge;
        end
    end

    assign q_ready = (state == S_IDLE);
    assign r_valid = (state == S_DONE);
    assign r_mask  = acc;
    assign busy    = (state != S_IDLE);

endmodule
